// File: rtl/se_fetch_unit.sv
// Instruction-fetch front end: fetch PC register, sequential incrementer, loadable
// synchronous-read instruction memory and a LOAD/RUN/HALT mode machine.
module se_fetch_unit #(
  parameter int              XLEN      = 64,
  parameter int              ILEN      = 32,
  parameter int              DEPTH     = 256,
  parameter int              STEP      = 4,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [ILEN-1:0] loadData_i,
  input  logic [XLEN-1:0] loadAddr_i,
  input  logic            wrEn_i,
  input  logic            start_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirectAddr_i,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] pco_o,
  output logic [XLEN-1:0] nextAddr_o,
  output logic            valid_o,
  output logic            misaligned_o,
  output logic [1:0]      state_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] pco_q, pco_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            mis_q, mis_d;
  logic            mem_we_s;
  logic [ILEN-1:0] rd_word_s;
  logic [ILEN-1:0] mem_q [DEPTH];

  // Only the word-index bits of the load address select a memory entry.
  logic unused_s;
  assign unused_s = ^{loadAddr_i[XLEN-1:AW+2], loadAddr_i[1:0]};

  assign rd_word_s = mem_q[fpc_q[2 +: AW]];

  // Instruction storage: written only while loading, never reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      mem_q[loadAddr_i[2 +: AW]] <= loadData_i;
    end
  end

  // Mode machine and fetch datapath next-state.
  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    pco_d    = pco_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    mis_d    = mis_q;
    mem_we_s = 1'b0;
    case (state_q)
      ST_LOAD: begin
        valid_d  = 1'b0;
        mem_we_s = wrEn_i;
        if (start_i) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (redirect_i) begin
          // Redirect wins over stall; a misaligned target traps without moving fpc.
          valid_d = 1'b0;
          if (redirectAddr_i[1:0] != 2'b00) begin
            state_d = ST_HALT;
            mis_d   = 1'b1;
          end else begin
            fpc_d = redirectAddr_i;
          end
        end else if (!stall_i) begin
          instr_d = rd_word_s;
          pco_d   = fpc_q;
          valid_d = 1'b1;
          fpc_d   = fpc_q + XLEN'(STEP);
        end else begin
          valid_d = valid_q;
        end
      end
      ST_HALT: begin
        valid_d = 1'b0;
        mis_d   = 1'b1;
      end
      default: begin
        state_d = ST_LOAD;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_LOAD;
      fpc_q   <= RESET_VEC;
      pco_q   <= RESET_VEC;
      instr_q <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      pco_q   <= pco_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  assign instr_o      = instr_q;
  assign pco_o        = pco_q;
  assign nextAddr_o   = pco_q + XLEN'(STEP);
  assign valid_o      = valid_q;
  assign misaligned_o = mis_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_se_fetch_unit.sv
// Self-checking bench for se_fetch_unit: directed vector table, trap/reset sequences,
// and randomized traffic against a behavioural model.
module tb_se_fetch_unit;
  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;
  localparam int STEP  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [ILEN-1:0] load_data;
  logic [XLEN-1:0] load_addr;
  logic            wr_en, start, stall, redirect;
  logic [XLEN-1:0] redirect_addr;
  logic [ILEN-1:0] instr;
  logic [XLEN-1:0] pco, next_addr;
  logic            valid, misaligned;
  logic [1:0]      state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  se_fetch_unit #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .STEP(STEP), .RESET_VEC(64'h0)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .loadData_i(load_data), .loadAddr_i(load_addr),
    .wrEn_i(wr_en), .start_i(start), .stall_i(stall), .redirect_i(redirect),
    .redirectAddr_i(redirect_addr), .instr_o(instr), .pco_o(pco), .nextAddr_o(next_addr),
    .valid_o(valid), .misaligned_o(misaligned), .state_o(state)
  );

  typedef struct {
    logic            wr;
    logic [XLEN-1:0] la;
    logic [ILEN-1:0] ld;
    logic            st;
    logic            stl;
    logic            rd;
    logic [XLEN-1:0] ra;
    logic            ev;
    logic [1:0]      es;
    logic            cpc;
    logic [XLEN-1:0] epc;
    logic [ILEN-1:0] ei;
  } vec_t;

  vec_t tbl[20];

  // behavioural model state
  int              m_mode;
  logic [XLEN-1:0] m_fpc, m_pc;
  logic [ILEN-1:0] m_instr;
  logic            m_valid, m_mis;
  logic [ILEN-1:0] m_mem[DEPTH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [1:0] es, input logic emis,
                           input logic cpc, input logic [XLEN-1:0] epc, input logic [ILEN-1:0] ei);
    chk({tag, ".valid"}, 64'(valid), 64'(ev));
    chk({tag, ".state"}, 64'(state), 64'(es));
    chk({tag, ".misaligned"}, 64'(misaligned), 64'(emis));
    if (cpc) begin
      chk({tag, ".pco"}, pco, epc);
      chk({tag, ".instr"}, 64'(instr), 64'(ei));
      chk({tag, ".nextAddr"}, next_addr, epc + 64'd4);
    end
  endtask

  task automatic drive(input logic wr, input logic [XLEN-1:0] la, input logic [ILEN-1:0] ld,
                       input logic st, input logic stl, input logic rd, input logic [XLEN-1:0] ra);
    wr_en = wr; load_addr = la; load_data = ld; start = st; stall = stl;
    redirect = rd; redirect_addr = ra;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int idx(input logic [XLEN-1:0] a);
    return int'((a / 64'd4) % 64'(DEPTH));
  endfunction

  task automatic model_reset();
    m_mode = 0; m_fpc = 64'h0; m_pc = 64'h0; m_instr = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
  endtask

  // Apply one clock edge worth of the mode rules to the model.
  task automatic model_step();
    if (m_mode == 0) begin
      if (wr_en) m_mem[idx(load_addr)] = load_data;
      if (start) m_mode = 1;
      m_valid = 1'b0;
    end else if (m_mode == 1) begin
      if (redirect) begin
        m_valid = 1'b0;
        if (redirect_addr % 64'd4 != 64'd0) begin
          m_mode = 2;
          m_mis  = 1'b1;
        end else begin
          m_fpc = redirect_addr;
        end
      end else if (!stall) begin
        m_instr = m_mem[idx(m_fpc)];
        m_pc    = m_fpc;
        m_valid = 1'b1;
        m_fpc   = m_fpc + 64'd4;
      end
    end
  endtask

  initial begin
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    check_out("reset", 1'b0, 2'd0, 1'b0, 1'b1, 64'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    //        wr    la                      ld            st    stl   rd    ra                      ev    es    cpc   epc                     ei
    tbl[0]  = '{1'b1, 64'h0,                 32'h00000013, 1'b0, 1'b0, 1'b0, 64'h0,                 1'b0, 2'd0, 1'b1, 64'h0,                 32'h0};
    tbl[1]  = '{1'b1, 64'h4,                 32'h00100093, 1'b0, 1'b0, 1'b0, 64'h0,                 1'b0, 2'd0, 1'b1, 64'h0,                 32'h0};
    tbl[2]  = '{1'b1, 64'h8,                 32'h00200113, 1'b0, 1'b0, 1'b0, 64'h0,                 1'b0, 2'd0, 1'b1, 64'h0,                 32'h0};
    tbl[3]  = '{1'b1, 64'hC,                 32'h00300193, 1'b1, 1'b0, 1'b0, 64'h0,                 1'b0, 2'd1, 1'b1, 64'h0,                 32'h0};
    tbl[4]  = '{1'b0, 64'h0,                 32'h0,        1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 2'd1, 1'b1, 64'h0,                 32'h00000013};
    tbl[5]  = '{1'b0, 64'h0,                 32'h0,        1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 2'd1, 1'b1, 64'h4,                 32'h00100093};
    tbl[6]  = '{1'b0, 64'h0,                 32'h0,        1'b0, 1'b1, 1'b0, 64'h0,                 1'b1, 2'd1, 1'b1, 64'h4,                 32'h00100093};
    tbl[7]  = '{1'b0, 64'h0,                 32'h0,        1'b0, 1'b1, 1'b0, 64'h0,                 1'b1, 2'd1, 1'b1, 64'h4,                 32'h00100093};
    tbl[8]  = '{1'b0, 64'h0,                 32'h0,        1'b0, 1'b1, 1'b0, 64'h0,                 1'b1, 2'd1, 1'b1, 64'h4,                 32'h00100093};
    tbl[9]  = '{1'b0, 64'h0,                 32'h0,        1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 2'd1, 1'b1, 64'h8,                 32'h00200113};
    tbl[10] = '{1'b0, 64'h0,                 32'h0,        1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 2'd1, 1'b1, 64'hC,                 32'h00300193};
    tbl[11] = '{1'b0, 64'h0,                 32'h0,        1'b0, 1'b1, 1'b1, 64'h0,                 1'b0, 2'd1, 1'b0, 64'h0,                 32'h0};
    tbl[12] = '{1'b0, 64'h0,                 32'h0,        1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 2'd1, 1'b1, 64'h0,                 32'h00000013};
    tbl[13] = '{1'b1, 64'h0,                 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 2'd1, 1'b1, 64'h4,                 32'h00100093};
    tbl[14] = '{1'b0, 64'h0,                 32'h0,        1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 2'd1, 1'b1, 64'h8,                 32'h00200113};
    tbl[15] = '{1'b0, 64'h0,                 32'h0,        1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 2'd1, 1'b1, 64'hC,                 32'h00300193};
    tbl[16] = '{1'b0, 64'h0,                 32'h0,        1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 2'd1, 1'b1, 64'h10,                32'h00000013};
    tbl[17] = '{1'b0, 64'h0,                 32'h0,        1'b0, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFC, 1'b0, 2'd1, 1'b0, 64'h0,                 32'h0};
    tbl[18] = '{1'b0, 64'h0,                 32'h0,        1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 2'd1, 1'b1, 64'hFFFFFFFFFFFFFFFC, 32'h00300193};
    tbl[19] = '{1'b0, 64'h0,                 32'h0,        1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 2'd1, 1'b1, 64'h0,                 32'h00000013};

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].wr, tbl[i].la, tbl[i].ld, tbl[i].st, tbl[i].stl, tbl[i].rd, tbl[i].ra);
      tick();
      check_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].es, 1'b0, tbl[i].cpc, tbl[i].epc, tbl[i].ei);
    end

    // misaligned redirect traps into HALT, which ignores every input
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b1, 64'h6);
    tick();
    check_out("trap", 1'b0, 2'd2, 1'b1, 1'b0, 64'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h0, 32'h0, 1'b1, i[0], 1'b1, 64'h8);
      tick();
      check_out($sformatf("halt%0d", i), 1'b0, 2'd2, 1'b1, 1'b0, 64'h0, 32'h0);
    end

    // asynchronous reset out of HALT, then mid-cycle during RUN
    #2 rst_n = 1'b0;
    #1 check_out("rst_halt", 1'b0, 2'd0, 1'b0, 1'b1, 64'h0, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0, 64'h0);
    tick();
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    tick();
    check_out("run_again", 1'b1, 2'd1, 1'b0, 1'b1, 64'h4, 32'h00100093);
    #2 rst_n = 1'b0;
    #1 check_out("rst_run", 1'b0, 2'd0, 1'b0, 1'b1, 64'h0, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // randomized traffic against the model
    model_reset();
    m_mem[0] = 32'h00000013; m_mem[1] = 32'h00100093;
    m_mem[2] = 32'h00200113; m_mem[3] = 32'h00300193;
    begin
      int hc;
      logic [XLEN-1:0] ra;
      hc = 0;
      for (int n = 0; n < 600; n++) begin
        if (m_mode == 2) hc++;
        if (m_mode == 2 && hc > 3) begin
          rst_n = 1'b0;
          #2 rst_n = 1'b1;
          model_reset();
          hc = 0;
        end
        ra = {$urandom, $urandom};
        if ($urandom_range(7) != 0) ra = ra & ~64'h3;
        if ($urandom_range(1) != 0) ra = ra & 64'h3F;
        drive($urandom_range(1) == 1, {$urandom, $urandom}, $urandom, $urandom_range(7) == 0,
              $urandom_range(3) == 0, $urandom_range(5) == 0, ra);
        tick();
        model_step();
        check_out($sformatf("rand%0d", n), m_valid, 2'(m_mode), m_mis, m_valid, m_pc, m_instr);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
